// File: rtl/ahb_stim_pkg.sv
// Shared AHB-Lite encodings, FSM state type and LFSR helper for the stimulus master.
package ahb_stim_pkg;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Right-shifting Galois step: feedback mask applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/stim_pattern_gen.sv
// Data pattern source: address-derived word by default, Galois LFSR when STIM_LFSR_EN is defined.
module stim_pattern_gen
  import ahb_stim_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter logic [31:0] SEED   = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              reload,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word
);

`ifdef STIM_LFSR_EN
  logic [31:0] lfsr;
  logic        unused_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= SEED;
    else if (reload)
      lfsr <= SEED;
    else if (advance)
      lfsr <= lfsr_next(lfsr);
  end

  assign word        = lfsr;
  assign unused_addr = ^addr;
`else
  logic unused_in;

  assign word      = {~addr[15:0], addr[15:0]};
  assign unused_in = ^{clk, reset, advance, reload, SEED, addr[ADDR_W-1:16]};
`endif

endmodule

// File: rtl/ahb_stim_master.sv
// AHB-Lite stimulus master: write burst, read-back, and expected-data strobe for a comparator.
// Build option STIM_LFSR_EN switches the data pattern to a seeded LFSR.
module ahb_stim_master
  import ahb_stim_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       SEED      = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic              HREADY,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       HWDATA,
  output logic [31:0]       exp_data,
  output logic              rd_sample,
  output logic              busy,
  output logic              done
);

  state_t      state;
  logic [15:0] count;
  logic [15:0] remain;
  logic        dp_valid;
  logic        dp_write;
  logic        beat;
  logic        last_beat;
  logic        wr_reload;
  logic        wr_adv;
  logic        rd_reload;
  logic        rd_adv;
  logic [31:0] wr_word;
  logic [31:0] rd_word;

  assign beat      = (HTRANS == HTRANS_NONSEQ);
  assign last_beat = (remain == 16'd1);
  assign wr_reload = HREADY && (state == ST_IDLE) && start;
  assign wr_adv    = HREADY && beat && HWRITE;
  assign rd_reload = HREADY && (state == ST_WRITE) && last_beat;
  assign rd_adv    = HREADY && beat && !HWRITE;
  assign rd_sample = dp_valid && !dp_write && HREADY;
  assign HSIZE     = HSIZE_WORD;

  stim_pattern_gen #(.ADDR_W(ADDR_W), .SEED(SEED)) u_wr_pat (
    .clk     (clk),
    .reset   (reset),
    .advance (wr_adv),
    .reload  (wr_reload),
    .addr    (HADDR),
    .word    (wr_word)
  );

  stim_pattern_gen #(.ADDR_W(ADDR_W), .SEED(SEED)) u_rd_pat (
    .clk     (clk),
    .reset   (reset),
    .advance (rd_adv),
    .reload  (rd_reload),
    .addr    (HADDR),
    .word    (rd_word)
  );

  // Everything, including the FSM, advances only on cycles where the bus completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      HTRANS   <= HTRANS_IDLE;
      HWRITE   <= 1'b0;
      HADDR    <= BASE_ADDR;
      HWDATA   <= '0;
      exp_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      remain   <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
    end else if (HREADY) begin
      dp_valid <= beat;
      dp_write <= HWRITE;
      if (beat && HWRITE)
        HWDATA <= wr_word;
      if (beat && !HWRITE)
        exp_data <= rd_word;
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state  <= ST_WRITE;
              count  <= num_words;
              remain <= num_words;
              HTRANS <= HTRANS_NONSEQ;
              HWRITE <= 1'b1;
              HADDR  <= BASE_ADDR;
              busy   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (last_beat) begin
            state  <= ST_READ;
            remain <= count;
            HWRITE <= 1'b0;
            HADDR  <= BASE_ADDR;
          end else begin
            remain <= remain - 16'd1;
            HADDR  <= HADDR + ADDR_W'(4);
          end
        end
        ST_READ: begin
          if (last_beat) begin
            state  <= ST_DRAIN;
            HTRANS <= HTRANS_IDLE;
          end else begin
            remain <= remain - 16'd1;
            HADDR  <= HADDR + ADDR_W'(4);
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_stim_master.sv
// Scoreboard bench for ahb_stim_master: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_ahb_stim_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start_w;
  logic [15:0] num_words;
  logic        HREADY;

  logic [31:0] HADDR, HWDATA, exp_data;
  logic [1:0]  HTRANS;
  logic        HWRITE, rd_sample, busy, done;
  logic [2:0]  HSIZE;

  logic [31:0] haddr_w, hwdata_w, exp_data_w;
  logic [1:0]  htrans_w;
  logic        hwrite_w, rd_sample_w, busy_w, done_w;
  logic [2:0]  hsize_w;

  always #5 clk = ~clk;

  ahb_stim_master dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .exp_data(exp_data), .rd_sample(rd_sample), .busy(busy), .done(done)
  );

  ahb_stim_master #(.BASE_ADDR(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .num_words(num_words), .HREADY(HREADY),
    .HADDR(haddr_w), .HTRANS(htrans_w), .HWRITE(hwrite_w), .HSIZE(hsize_w), .HWDATA(hwdata_w),
    .exp_data(exp_data_w), .rd_sample(rd_sample_w), .busy(busy_w), .done(done_w)
  );

`ifdef STIM_LFSR_EN
  localparam logic [31:0] PAT [4] = '{32'hACE1_0001, 32'hD650_8003, 32'hEB08_4002, 32'h7584_2001};
  localparam logic [31:0] PAT_W [3] = '{32'hACE1_0001, 32'hD650_8003, 32'hEB08_4002};
`else
  localparam logic [31:0] PAT [4] = '{32'hFFFF_0000, 32'hFFFB_0004, 32'hFFF7_0008, 32'hFFF3_000C};
  localparam logic [31:0] PAT_W [3] = '{32'h0007_FFF8, 32'h0003_FFFC, 32'hFFFF_0000};
`endif
  localparam logic [31:0] ADDR_W_TBL [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] data; int cyc; } rd_t;

  beat_t addr_q[$];
  rd_t   rd_q[$];
  int    done_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (start || start_w) cyc <= 1;
    else cyc <= cyc + 1;
  end

  logic        wd_pend = 1'b0;
  logic [31:0] wd_exp;
  logic        frz_pend = 1'b0;
  logic [31:0] s_haddr, s_hwdata, s_exp;
  logic [5:0]  s_ctl;

  always @(negedge clk) begin
    beat_t b;
    rd_t   r;
    int    d;
    if (reset) begin
      wd_pend  = 1'b0;
      frz_pend = 1'b0;
    end else begin
      if (frz_pend) begin
        chk("frz_haddr", HADDR, s_haddr);
        chk("frz_hwdata", HWDATA, s_hwdata);
        chk("frz_exp", exp_data, s_exp);
        chk("frz_ctl", {26'd0, HTRANS, HWRITE, busy, done, rd_sample}, {26'd0, s_ctl});
      end
      if (wd_pend) begin
        chk("hwdata", HWDATA, wd_exp);
        wd_pend = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        if (addr_q.size() == 0) chk("extra_beat", {31'd0, 1'b1}, 32'd0);
        else begin
          b = addr_q.pop_front();
          chk("haddr", HADDR, b.addr);
          chk("hwrite", {31'd0, HWRITE}, {31'd0, b.wr});
          chk("hsize", {29'd0, HSIZE}, 32'd2);
          if (b.wr) begin
            wd_pend = 1'b1;
            wd_exp  = b.data;
          end
        end
      end
      if (rd_sample) begin
        if (rd_q.size() == 0) chk("extra_rd_sample", {31'd0, 1'b1}, 32'd0);
        else begin
          r = rd_q.pop_front();
          chk("exp_data", exp_data, r.data);
          chk("rd_cycle", cyc, r.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) chk("extra_done", {31'd0, 1'b1}, 32'd0);
        else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      if (busy) busy_seen = 1'b1;
      frz_pend = !HREADY;
      s_haddr  = HADDR;
      s_hwdata = HWDATA;
      s_exp    = exp_data;
      s_ctl    = {HTRANS, HWRITE, busy, done, rd_sample};
    end
  end

  task automatic push_seq(input int n, input int stall);
    beat_t b;
    rd_t   r;
    for (int k = 0; k < n; k++) begin
      b.addr = 32'(4 * k); b.wr = 1'b1; b.data = PAT[k];
      addr_q.push_back(b);
    end
    for (int k = 0; k < n; k++) begin
      b.addr = 32'(4 * k); b.wr = 1'b0; b.data = 32'h0;
      addr_q.push_back(b);
      r.data = PAT[k]; r.cyc = n + 2 + k + stall;
      rd_q.push_back(r);
    end
    done_q.push_back(n == 0 ? 1 : 2 * n + 2 + stall);
  endtask

  task automatic kick(input int n);
    start = 1'b1;
    num_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == n0; i++) @(posedge clk);
    #1;
    chk("done_seen", {31'd0, done_cnt > n0}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("addr_q_left", addr_q.size(), 32'd0);
    chk("rd_q_left", rd_q.size(), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_exp", exp_data, 32'h0);
    chk("rst_ctl", {24'd0, HTRANS, HWRITE, HSIZE, busy, done}, {24'd0, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0});
    chk("rst_rd_sample", {31'd0, rd_sample}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_w = 1'b0; HREADY = 1'b1; num_words = '0;
    repeat (3) @(posedge clk); #1;
    chk_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset();

    // Four beats, zero wait.
    push_seq(4, 0); kick(4); wait_done();

    // Second write stalled for three cycles.
    push_seq(4, 3); kick(4);
    @(posedge clk); #1; HREADY = 1'b0;
    repeat (3) @(posedge clk); #1; HREADY = 1'b1;
    wait_done();

    // Zero-length request.
    busy_seen = 1'b0;
    push_seq(0, 0); kick(0); wait_done();
    chk("busy_nw0", {31'd0, busy_seen}, 32'd0);

    // Two beats.
    push_seq(2, 0); kick(2); wait_done();

    // Address wrap on the second instance, checked cycle by cycle.
    start_w = 1'b1; num_words = 16'd3;
    @(posedge clk); #1; start_w = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 6) begin
        chk("wrap_haddr", haddr_w, ADDR_W_TBL[(c - 1) % 3]);
        chk("wrap_hwrite", {31'd0, hwrite_w}, {31'd0, c <= 3});
      end
      if (c >= 2 && c <= 4) chk("wrap_hwdata", hwdata_w, PAT_W[c - 2]);
      if (c >= 5 && c <= 7) chk("wrap_exp", exp_data_w, PAT_W[c - 5]);
      chk("wrap_rd_sample", {31'd0, rd_sample_w}, {31'd0, c >= 5 && c <= 7});
      chk("wrap_done", {31'd0, done_w}, {31'd0, c == 8});
      @(posedge clk); #1;
    end

    // Reset in the middle of the read phase, then a clean rerun.
    push_seq(4, 0); kick(4);
    repeat (6) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset();
    addr_q.delete(); rd_q.delete(); done_q.delete();
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    push_seq(4, 0); kick(4); wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_stim_master.md
# ahb_stim_master

AHB-Lite stimulus initiator for the SDRAM verification testbench. On a start pulse it issues a burst of single-word NONSEQ writes to consecutive addresses, then reads the same addresses back. One master drives the DUV and the golden model in lockstep. For every read data phase it presents the expected word and a sample strobe, so the downstream read-data comparator knows when and what to compare.

## Interface
- ADDR_W, 32, address bus width
- BASE_ADDR, 32'h0000_0000, first transfer address (word aligned)
- SEED, 32'hACE1_0001, pattern seed (used only when STIM_LFSR_EN is defined)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE
- num_words  in  16  beats per phase; sampled with start
- HREADY  in  1  DUV transfer-done; stalls the whole pipeline when low
- HADDR  out  ADDR_W  address-phase address
- HTRANS  out  2  2'b10 NONSEQ on a valid beat, 2'b00 IDLE otherwise
- HWRITE  out  1  1 during write address phases
- HSIZE  out  3  fixed 3'b010 (word)
- HWDATA  out  32  write data, driven in the write data phase
- exp_data  out  32  expected HRDATA for the current read data phase
- rd_sample  out  1  high in a read data phase when HREADY=1 (the comparator samples here)
- busy  out  1  high from the first address phase through DRAIN
- done  out  1  one-cycle pulse at sequence end

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On start with num_words≠0, latch count and go to WRITE.
  - On start with num_words=0, go to DONE; no transfers are issued.
- WRITE:
  - Each accepted beat (HREADY=1) issues HTRANS=NONSEQ, HWRITE=1, HADDR=BASE_ADDR+4·k.
  - After beat num_words-1 is accepted, go to READ with k reset to 0.
- READ:
  - Same addresses with HWRITE=0.
  - After the last beat is accepted, go to DRAIN.
- DRAIN: HTRANS=IDLE; wait for the last read data phase to complete (HREADY=1), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Data phase:
  - A registered copy of the previous accepted address-phase control (valid, write, index) defines the current data phase.
  - HWDATA = pattern(index) while the data phase is a write; otherwise hold the last value.
  - exp_data = pattern(index) while the data phase is a read.
  - rd_sample = read data phase & HREADY.
- Address arithmetic: increment by 4, modulo 2^ADDR_W, so the address wraps silently past the top of the range.
- HREADY low: hold all address-phase and data-phase outputs and the state unchanged.
- start while not IDLE: ignored.
- Reset (including mid-sequence): state IDLE; HTRANS=00, HWRITE=0, HADDR=BASE_ADDR, HSIZE=3'b010; HWDATA=0, exp_data=0, rd_sample=0, busy=0, done=0; the pending data phase is discarded.

## Timing
- start sampled at edge 0; first write address phase is in cycle 1.
- Zero-wait latency:
  - Write addresses occupy cycles 1..N.
  - Read addresses occupy cycles N+1..2N; the first read address overlaps the last write data phase.
  - DRAIN is cycle 2N+1.
  - done is high in cycle 2N+2.
- Each cycle with HREADY=0 adds exactly one cycle to every subsequent event.
- rd_sample for read k occurs in the cycle after read k's address is accepted.

## Configuration
- STIM_LFSR_EN defined:
  - pattern(k) is the k-th state of a 32-bit Galois LFSR (taps 0x8020_0003) seeded with SEED; k=0 gives SEED.
  - The read side runs a second LFSR instance, reseeded on entry to READ, so exp_data matches the written data.
- STIM_LFSR_EN undefined: pattern(k) = {~addr[15:0], addr[15:0]}, where addr = BASE_ADDR+4·k; no LFSR logic is built.

## Structure
- Package ahb_stim_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ
  - HSIZE_WORD
  - the state enum
  - the LFSR tap constant
- Sub-module stim_pattern_gen (inputs: advance, reload, index/addr; output: word) wraps both pattern modes. It is instantiated twice: once for the write side, once for the expected-data side.

## Test plan
- Reset, then num_words=4 with zero wait, BASE_ADDR=0 and LFSR off:
  - HADDR sequence is 0,4,8,C,0,4,8,C; HWDATA of the first write is FFFF_0000.
  - rd_sample is high in cycles 6..9 with exp_data FFFF_0000, FFFB_0004, …; done is high in cycle 10.
- HREADY low for 3 cycles during the second write: all outputs frozen; done arrives in cycle 13.
- num_words=0: no NONSEQ beats; busy stays 0; done is high in cycle 1.
- BASE_ADDR=FFFF_FFF8 with num_words=3: addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000 in both phases.
- reset asserted mid-READ: outputs go to their reset values immediately; a new start then runs a full sequence correctly.
- STIM_LFSR_EN defined, num_words=2: HWDATA is ACE1_0001 then its LFSR successor; exp_data matches in order.
